// File: rtl/uart_avm_pkg.sv
// Shared definitions for the UART Avalon-MM responder: register map, status bit indices and
// FSM state types.
package uart_avm_pkg;

   localparam logic [4:0] RX_BASE     = 5'd0;
   localparam logic [4:0] TX_BASE     = 5'd4;
   localparam logic [4:0] STATUS_BASE = 5'd8;

   localparam int unsigned RX_OK_BIT   = 7;
   localparam int unsigned TX_OK_BIT   = 6;
   localparam int unsigned RX_OVR_BIT  = 3;
   localparam int unsigned RX_FERR_BIT = 2;

   typedef enum logic [1:0] {TIdle, TStart, TData, TStop} tx_state_e;
   typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;

   function automatic logic [31:0] status_word(input logic rx_ok, input logic tx_ok,
                                               input logic ovr, input logic ferr);
      logic [31:0] w;
      w = '0;
      w[RX_OK_BIT]   = rx_ok;
      w[TX_OK_BIT]   = tx_ok;
      w[RX_OVR_BIT]  = ovr;
      w[RX_FERR_BIT] = ferr;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 serial receiver: 2-flop synchronizer, bit timing and RX FSM. Emits a one-cycle push
// (good stop bit) or ferr (bad stop bit) pulse together with the assembled byte.
module uart_rx_deser
   import uart_avm_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rxd_i,
   output logic [7:0] byte_o,
   output logic       push_o,
   output logic       ferr_o
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]      sync_q;
   logic            rx_s;
   rx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;

   assign rx_s   = sync_q[1];
   assign byte_o = shift_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         state_q <= RIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], rxd_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      push_o  = 1'b0;
      ferr_o  = 1'b0;
      case (state_q)
         RIdle: begin
            cnt_d = '0;
            if (!rx_s) state_d = RStart;
         end
         RStart: begin
            // Mid-start sample: a high line here was a glitch, not a frame.
            if (cnt_q == CntHalf) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? RIdle : RData;
            end
         end
         RData: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RStop;
            end
         end
         RStop: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = RIdle;
               push_o  = rx_s;
               ferr_o  = !rx_s;
            end
         end
         default: state_d = RIdle;
      endcase
   end

endmodule

// File: rtl/uart_avm_responder.sv
// Avalon-MM UART responder: RX/TX/STATUS registers with one wait state, TX serializer and RX
// storage. Define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module uart_avm_responder
   import uart_avm_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   input  logic [4:0]  avm_address,
   input  logic        avm_read,
   output logic [31:0] avm_readdata,
   input  logic        avm_write,
   input  logic [31:0] avm_writedata,
   output logic        avm_waitrequest,
   input  logic        uart_rxd,
   output logic        uart_txd
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   logic        req, accept, ack_q;
   logic [31:0] readdata_q, rd_mux;
   logic        rd_pop_q, pop, tx_load, stat_clr;
   logic        rx_ok, tx_ok, ovr_q, ferr_q;
   logic [7:0]  rx_head, rx_byte;
   logic        rx_push, rx_ferr, push_ok, overrun;
   logic        unused_wdata;

   assign unused_wdata = ^avm_writedata[31:8];

   // Bus: first request cycle stalls and registers read data, the following cycle accepts.
   assign req             = avm_read | avm_write;
   assign avm_waitrequest = req & !ack_q;
   assign accept          = req & ack_q;
   assign avm_readdata    = readdata_q;

   assign pop      = accept & avm_read & rd_pop_q;
   assign tx_load  = accept & avm_write & (avm_address == TX_BASE) & tx_ok;
   assign stat_clr = accept & avm_write & (avm_address == STATUS_BASE);

   always_comb begin
      rd_mux = '0;
      if (avm_address == RX_BASE) begin
         if (rx_ok) rd_mux = {24'b0, rx_head};
      end else if (avm_address == STATUS_BASE) begin
         rd_mux = status_word(rx_ok, tx_ok, ovr_q, ferr_q);
      end
   end

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         ack_q      <= 1'b0;
         readdata_q <= '0;
         rd_pop_q   <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         ack_q <= req & !ack_q;
         if (req & !ack_q & avm_read) begin
            readdata_q <= rd_mux;
            // Pop only what the read actually returned; a later push must not be lost.
            rd_pop_q   <= (avm_address == RX_BASE) & rx_ok;
         end
         ovr_q  <= overrun | (ovr_q & !stat_clr);
         ferr_q <= rx_ferr | (ferr_q & !stat_clr);
      end
   end

   uart_rx_deser #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_deser (
      .clk_i (avm_clk),
      .rst_i (avm_rst),
      .rxd_i (uart_rxd),
      .byte_o(rx_byte),
      .push_o(rx_push),
      .ferr_o(rx_ferr)
   );

   assign overrun = rx_push & !push_ok;

`ifdef UART_RX_FIFO_EN
   logic [7:0] fifo_q [4];
   logic [1:0] wptr_q, rptr_q;
   logic [2:0] fcnt_q;

   assign rx_ok   = (fcnt_q != 3'd0);
   assign rx_head = fifo_q[rptr_q];
   assign push_ok = rx_push & ((fcnt_q != 3'd4) | pop);

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
      end else begin
         if (push_ok) begin
            fifo_q[wptr_q] <= rx_byte;
            wptr_q         <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         fcnt_q <= fcnt_q + 3'(push_ok) - 3'(pop);
      end
   end
`else
   logic [7:0] hold_q;
   logic       full_q;

   assign rx_ok   = full_q;
   assign rx_head = hold_q;
   assign push_ok = rx_push & (!full_q | pop);

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else begin
         if (push_ok) hold_q <= rx_byte;
         full_q <= push_ok | (full_q & !pop);
      end
   end
`endif

   tx_state_e       tx_state_q, tx_state_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            txd_q, txd_d;

   assign tx_ok    = (tx_state_q == TIdle);
   assign uart_txd = txd_q;

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         tx_state_q <= TIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      case (tx_state_q)
         TIdle: begin
            tx_cnt_d = '0;
            txd_d    = 1'b1;
            if (tx_load) begin
               tx_state_d = TStart;
               tx_shift_d = avm_writedata[7:0];
               txd_d      = 1'b0;
            end
         end
         TStart: begin
            if (tx_cnt_q == CntLast) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TData;
               txd_d      = tx_shift_q[0];
            end
         end
         TData: begin
            if (tx_cnt_q == CntLast) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TStop;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 1'b1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  txd_d      = tx_shift_q[1];
               end
            end
         end
         TStop: begin
            if (tx_cnt_q == CntLast) begin
               tx_cnt_d   = '0;
               tx_state_d = TIdle;
               txd_d      = 1'b1;
            end
         end
         default: tx_state_d = TIdle;
      endcase
   end

endmodule
